// File: rtl/operator_sequencer.sv
// Keypad-driven sequencer: collects operand A, an operator and operand B,
// fires the external operator datapath for one cycle and captures its result.
module operator_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic [7:0] op_result,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] OP,
  output logic       E,
  output logic [7:0] result,
  output logic       sinal,
  output logic       done,
  output logic       erro,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GOT_A  = 3'd1,
    S_GOT_OP = 3'd2,
    S_GOT_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_SHOW   = 3'd5
  } state_t;

  localparam logic [3:0] KEY_MUL   = 4'b1010;
  localparam logic [3:0] KEY_SUB   = 4'b1011;
  localparam logic [3:0] KEY_ADD   = 4'b1100;
  localparam logic [3:0] KEY_EQ    = 4'b1101;
  localparam logic [3:0] KEY_CLEAR = 4'b1110;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_operator(input logic [3:0] k);
    return (k == KEY_MUL) || (k == KEY_SUB) || (k == KEY_ADD);
  endfunction

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] op_q, op_d;
  logic [7:0] result_q, result_d;
  logic       erro_q, erro_d;
  logic       e_q, e_d;
  logic       done_q, done_d;

  logic dig_s, opr_s, eq_s, clr_s;

  // Key decode; EXEC never samples the keypad, so clear is masked there too
  always_comb begin
    dig_s = key_valid && is_digit(key);
    opr_s = key_valid && is_operator(key);
    eq_s  = key_valid && (key == KEY_EQ);
    clr_s = key_valid && (key == KEY_CLEAR) && (state_q != S_EXEC);
  end

  // Next-state and register-update logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    erro_d   = erro_q;
    if (clr_s) begin
      state_d  = S_IDLE;
      a_d      = 4'd0;
      b_d      = 4'd0;
      op_d     = 4'd0;
      result_d = 8'd0;
      erro_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dig_s) begin
            a_d     = key;
            erro_d  = 1'b0;
            state_d = S_GOT_A;
          end else if (opr_s || eq_s) begin
            erro_d = 1'b1;
          end else begin
            erro_d = erro_q;
          end
        end
        S_GOT_A: begin
          if (dig_s) begin
            a_d    = key;
            erro_d = 1'b0;
          end else if (opr_s) begin
            op_d    = key;
            erro_d  = 1'b0;
            state_d = S_GOT_OP;
          end else if (eq_s) begin
            erro_d = 1'b1;
          end else begin
            erro_d = erro_q;
          end
        end
        S_GOT_OP: begin
          if (opr_s) begin
            op_d   = key;
            erro_d = 1'b0;
          end else if (dig_s) begin
            b_d     = key;
            erro_d  = 1'b0;
            state_d = S_GOT_B;
          end else if (eq_s) begin
            erro_d = 1'b1;
          end else begin
            erro_d = erro_q;
          end
        end
        S_GOT_B: begin
          if (dig_s) begin
            b_d    = key;
            erro_d = 1'b0;
          end else if (eq_s) begin
            erro_d  = 1'b0;
            state_d = S_EXEC;
          end else if (opr_s) begin
            erro_d = 1'b1;
          end else begin
            erro_d = erro_q;
          end
        end
        S_EXEC: begin
          result_d = op_result;
          state_d  = S_SHOW;
        end
        S_SHOW: begin
          if (dig_s) begin
            a_d     = key;
            b_d     = 4'd0;
            op_d    = 4'd0;
            erro_d  = 1'b0;
            state_d = S_GOT_A;
          end else if (opr_s || eq_s) begin
            erro_d = 1'b1;
          end else begin
            erro_d = erro_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state so they align with estado
  always_comb begin
    e_d    = (state_d == S_EXEC);
    done_d = (state_q == S_EXEC) && (state_d == S_SHOW);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      op_q     <= 4'd0;
      result_q <= 8'd0;
      erro_q   <= 1'b0;
      e_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      erro_q   <= erro_d;
      e_q      <= e_d;
      done_q   <= done_d;
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign OP     = op_q;
  assign E      = e_q;
  assign result = result_q;
  assign sinal  = result_q[7];
  assign done   = done_q;
  assign erro   = erro_q;
  assign estado = state_q;

endmodule
